// File: rtl/avr_data_bus.sv
// AVR data-space responder: SRAM, I/O window forwarding and open-bus reads; read data one cycle after request.
// After every reset the SRAM is swept to zero while busy stalls the core; core requests are ignored until then.
module avr_data_bus #(
  parameter int          RAM_AW   = 12,
  parameter logic [15:0] IO_BASE  = 16'h0020,
  parameter logic [15:0] RAM_BASE = 16'h0100,
  parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] address,
  input  logic [7:0]  o_data,
  input  logic        we,
  input  logic        re,
  output logic [7:0]  i_data,
  output logic        busy,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  output logic        io_we,
  output logic        io_re,
  input  logic [7:0]  io_rdata
);

  localparam int          RAM_DEPTH = 2 ** RAM_AW;
  localparam logic [16:0] RAM_TOP   = {1'b0, RAM_BASE} + 17'(RAM_DEPTH);

  typedef enum logic [1:0] {REG_NONE, REG_IO, REG_RAM} region_e;
  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [RAM_AW-1:0]   r_clr_ptr;
  region_e             r_region;
  region_e             w_region;
  logic [RAM_AW-1:0]   w_offset;
  logic                w_run;
  logic                w_ram_we;
  logic                w_io_req;
  logic [7:0]          r_mem [0:RAM_DEPTH-1];
  logic [7:0]          r_ram_rdata;
  logic [7:0]          r_io_addr;
  logic [7:0]          r_io_wdata;
  logic                r_io_we;
  logic                r_io_re;

  assign w_run = (r_state == ST_RUN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) begin
        r_clr_ptr <= r_clr_ptr + RAM_AW'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_CLEAR && r_clr_ptr == '1) begin
      w_state_nxt = ST_RUN;
    end
  end

  // 17-bit compare keeps the SRAM upper bound correct even when the SRAM reaches the top of the 16-bit space.
  always_comb begin
    w_region = REG_NONE;
    if (address >= IO_BASE && address < RAM_BASE) begin
      w_region = REG_IO;
    end else if ({1'b0, address} >= {1'b0, RAM_BASE} && {1'b0, address} < RAM_TOP) begin
      w_region = REG_RAM;
    end
  end

  assign w_offset = address[RAM_AW-1:0] - RAM_BASE[RAM_AW-1:0];
  assign w_ram_we = w_run && (w_region == REG_RAM) && we;
  assign w_io_req = w_run && (w_region == REG_IO) && (we || re);

  // Read-first: the registered read samples the array before this edge's write lands.
  always_ff @(posedge clock) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_ram_we) begin
      r_mem[w_offset] <= o_data;
    end
    r_ram_rdata <= r_mem[w_offset];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_region   <= REG_NONE;
      r_io_addr  <= '0;
      r_io_wdata <= '0;
      r_io_we    <= 1'b0;
      r_io_re    <= 1'b0;
    end else begin
      r_region <= (w_run && re) ? w_region : REG_NONE;
      if (w_io_req) begin
        r_io_addr  <= address[7:0];
        r_io_wdata <= o_data;
        r_io_we    <= we;
        r_io_re    <= re;
      end else begin
        r_io_we <= 1'b0;
        r_io_re <= 1'b0;
      end
    end
  end

  always_comb begin
    i_data = OPEN_BUS;
    case (r_region)
      REG_RAM:  i_data = r_ram_rdata;
      REG_IO:   i_data = io_rdata;
      default:  i_data = OPEN_BUS;
    endcase
  end

  assign busy     = ~w_run;
  assign io_addr  = r_io_addr;
  assign io_wdata = r_io_wdata;
  assign io_we    = r_io_we;
  assign io_re    = r_io_re;

endmodule

// File: tb/tb_avr_data_bus.sv
// Directed bench for avr_data_bus with a 16-byte SRAM.
module tb_avr_data_bus;

  logic        clock;
  logic        reset_n;
  logic [15:0] address;
  logic [7:0]  o_data;
  logic        we;
  logic        re;
  logic [7:0]  i_data;
  logic        busy;
  logic [7:0]  io_addr;
  logic [7:0]  io_wdata;
  logic        io_we;
  logic        io_re;
  logic [7:0]  io_rdata;

  int checks;
  int errors;
  int n;

  avr_data_bus #(
    .RAM_AW   (4),
    .IO_BASE  (16'h0020),
    .RAM_BASE (16'h0100),
    .OPEN_BUS (8'hFF)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .address  (address),
    .o_data   (o_data),
    .we       (we),
    .re       (re),
    .i_data   (i_data),
    .busy     (busy),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_we    (io_we),
    .io_re    (io_re),
    .io_rdata (io_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    we = 1'b0;
    re = 1'b0;
  endtask

  task automatic count_busy(input string tag);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk(tag, 16'(n), 16'd16);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset_n  = 1'b0;
    address  = 16'h0000;
    o_data   = 8'h00;
    we       = 1'b0;
    re       = 1'b0;
    io_rdata = 8'h5A;

    step();
    step();
    chk("rst_busy", 16'(busy), 16'd1);
    chk("rst_idata", 16'(i_data), 16'h00FF);
    chk("rst_io_addr", 16'(io_addr), 16'h0000);
    chk("rst_io_wdata", 16'(io_wdata), 16'h0000);
    chk("rst_strobes", 16'({io_we, io_re}), 16'd0);

    reset_n = 1'b1;
    count_busy("busy_len");

    for (int a = 0; a < 16; a++) begin
      address = 16'h0100 + 16'(a);
      re = 1'b1;
      step();
      chk($sformatf("clr_rd_%0h", a), 16'(i_data), 16'h0000);
    end
    idle();

    address = 16'h0105; o_data = 8'hA5; we = 1'b1;
    step();
    we = 1'b0; re = 1'b1;
    step();
    chk("ram_wr_rd", 16'(i_data), 16'h00A5);

    o_data = 8'h3C; we = 1'b1; re = 1'b1;
    step();
    chk("ram_rd_first", 16'(i_data), 16'h00A5);
    we = 1'b0;
    step();
    chk("ram_rd_new", 16'(i_data), 16'h003C);
    idle();
    step();
    chk("idle_open_bus", 16'(i_data), 16'h00FF);

    address = 16'h003F; o_data = 8'h80; we = 1'b1;
    step();
    chk("io_wr_we", 16'(io_we), 16'd1);
    chk("io_wr_re", 16'(io_re), 16'd0);
    chk("io_wr_addr", 16'(io_addr), 16'h003F);
    chk("io_wr_wdata", 16'(io_wdata), 16'h0080);
    idle();
    address = 16'h0000; o_data = 8'h00;
    step();
    chk("io_wr_pulse_end", 16'(io_we), 16'd0);
    chk("io_addr_held", 16'(io_addr), 16'h003F);
    chk("io_wdata_held", 16'(io_wdata), 16'h0080);

    address = 16'h0025; re = 1'b1;
    step();
    chk("io_rd_re", 16'(io_re), 16'd1);
    chk("io_rd_addr", 16'(io_addr), 16'h0025);
    chk("io_rd_data", 16'(i_data), 16'h005A);
    address = 16'h0026;
    step();
    chk("io_b2b_re", 16'(io_re), 16'd1);
    chk("io_b2b_addr", 16'(io_addr), 16'h0026);
    idle();
    step();
    chk("io_rd_pulse_end", 16'(io_re), 16'd0);

    address = 16'h0030; o_data = 8'h42; we = 1'b1; re = 1'b1;
    step();
    chk("io_both_strobes", 16'({io_we, io_re}), 16'h0003);
    chk("io_both_data", 16'(i_data), 16'h005A);
    idle();

    address = 16'h0000; re = 1'b1;
    step();
    chk("none_rd_0000", 16'(i_data), 16'h00FF);
    address = 16'h001F;
    step();
    chk("none_rd_001F", 16'(i_data), 16'h00FF);
    address = 16'h0110;
    step();
    chk("none_rd_0110", 16'(i_data), 16'h00FF);
    chk("none_no_io", 16'({io_we, io_re}), 16'd0);
    re = 1'b0; o_data = 8'h11; we = 1'b1;
    step();
    chk("none_wr_no_io", 16'({io_we, io_re}), 16'd0);
    idle();
    address = 16'h0100; re = 1'b1;
    step();
    chk("none_wr_dropped", 16'(i_data), 16'h0000);
    idle();

    address = 16'h0107; o_data = 8'h77; we = 1'b1;
    step();
    address = 16'h003F; o_data = 8'h99; we = 1'b1;
    step();
    chk("pre_rst_io_we", 16'(io_we), 16'd1);
    idle();
    reset_n = 1'b0;
    #1;
    chk("rst_async_strobe", 16'(io_we), 16'd0);
    chk("rst_async_busy", 16'(busy), 16'd1);
    chk("rst_async_addr", 16'(io_addr), 16'h0000);
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 7; k++) step();
    chk("mid_sweep_busy", 16'(busy), 16'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 16'(busy), 16'd1);
    chk("mid_rst_strobes", 16'({io_we, io_re}), 16'd0);
    step();
    address = 16'h0103; o_data = 8'hEE; we = 1'b1;
    reset_n = 1'b1;
    count_busy("busy_len_again");
    we = 1'b0;
    chk("busy_no_io", 16'({io_we, io_re}), 16'd0);
    re = 1'b1;
    step();
    chk("busy_wr_ignored", 16'(i_data), 16'h0000);
    address = 16'h0107;
    step();
    chk("reclear_0107", 16'(i_data), 16'h0000);
    address = 16'h0105;
    step();
    chk("reclear_0105", 16'(i_data), 16'h0000);
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
